// File: rtl/lin_interp_upsampler.sv
// Linear-interpolating upsampler: each accepted WIDTH-bit sample yields 2**LOG2_L outputs ramping from
// the previous sample toward it. Define LIN_INTERP_ROUND_EN for round-half-up instead of floor.
module lin_interp_upsampler #(
   parameter int WIDTH  = 8,
   parameter int LOG2_L = 2
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic [WIDTH-1:0] Din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic [WIDTH-1:0] Dout,
   output logic             dout_valid,
   input  logic             dout_ready
);

   localparam int                L      = 1 << LOG2_L;
   localparam int                ACC_W  = WIDTH + LOG2_L + 1;
   localparam logic [LOG2_L-1:0] K_LAST = '1;
   localparam logic [LOG2_L-1:0] K_ONE  = LOG2_L'(1);
   localparam logic [LOG2_L:0]   L_W    = (LOG2_L + 1)'(L);

   typedef enum logic {S_WAIT, S_EMIT} state_t;

   state_t            state, state_n;
   logic [WIDTH-1:0]  prev, prev_n;
   logic [WIDTH-1:0]  cur, cur_n;
   logic [WIDTH-1:0]  dout_n;
   logic [LOG2_L-1:0] k, k_n;
   logic              accept;

   // Weighted blend ((L-ph)*a + ph*b) >> LOG2_L; the maximum always fits back in WIDTH.
   function automatic logic [WIDTH-1:0] interp(input logic [WIDTH-1:0]  a,
                                               input logic [WIDTH-1:0]  b,
                                               input logic [LOG2_L-1:0] ph);
      logic [LOG2_L:0]  wa, wb;
      logic [ACC_W-1:0] acc;
      wb  = {1'b0, ph};
      wa  = L_W - wb;
      acc = ACC_W'(wa) * ACC_W'(a) + ACC_W'(wb) * ACC_W'(b);
`ifdef LIN_INTERP_ROUND_EN
      acc = acc + ACC_W'(L / 2);
`endif
      return WIDTH'(acc >> LOG2_L);
   endfunction

   // Ready is combinational from dout_ready so a new sample lands on the last phase with no bubble.
   assign din_ready  = (state == S_WAIT) || (state == S_EMIT && k == K_LAST && dout_ready);
   assign accept     = din_valid && din_ready;
   assign dout_valid = (state == S_EMIT);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch),
      // and combinational logic uses blocking '=' while the state register below uses '<='.
      state_n = state;
      prev_n  = prev;
      cur_n   = cur;
      k_n     = k;
      dout_n  = Dout;
      if (accept) begin
         prev_n  = cur;
         cur_n   = Din;
         k_n     = '0;
         state_n = S_EMIT;
         dout_n  = interp(cur, Din, '0);
      end else if (state == S_EMIT && dout_ready) begin
         if (k == K_LAST) begin
            state_n = S_WAIT;
         end else begin
            k_n    = k + K_ONE;
            dout_n = interp(prev, cur, k + K_ONE);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state <= S_WAIT;
         prev  <= '0;
         cur   <= '0;
         k     <= '0;
         Dout  <= '0;
      end else begin
         state <= state_n;
         prev  <= prev_n;
         cur   <= cur_n;
         k     <= k_n;
         Dout  <= dout_n;
      end
   end

endmodule

// File: doc/lin_interp_upsampler.md
Name: lin_interp_upsampler

Overview:
- Rate-increasing counterpart to the team's moving-average FIR stage: accepts 8-bit samples and emits L = 2**LOG2_L linearly interpolated samples per input.
- Sits between a low-rate sample source and the high-rate processing/DAC path.
- Valid/ready handshake on both sides; sustains one output per clock when unthrottled.

Parameters:
- WIDTH, 8, sample width in bits (unsigned).
- LOG2_L, 2, log2 of the interpolation factor L. Legal range is 1..4; the default gives L = 4.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- Din  input  WIDTH  input sample.
- din_valid  input  1  Din is valid.
- din_ready  output  1  block accepts Din this cycle.
- Dout  output  WIDTH  interpolated output sample.
- dout_valid  output  1  Dout is valid.
- dout_ready  input  1  downstream accepts Dout this cycle.

Behaviour:
- Clocking and reset: one clock (CLK). Reset is synchronous and active-high.
- Reset values: state = WAIT; prev = 0; cur = 0; k = 0; dout_valid = 0; Dout = 0; din_ready = 1 (follows from WAIT).
- Registers:
  - prev, cur: the two most recent input samples.
  - k: phase counter, LOG2_L bits.
  - state: WAIT or EMIT.
- Input handshake: an input is accepted when din_valid && din_ready. On accept: prev <= cur; cur <= Din; k <= 0; state <= EMIT.
- Output value: Dout = ((L-k)*prev + k*cur) >> LOG2_L.
  - Intermediate width is WIDTH+LOG2_L+1; the result always fits in WIDTH, so no saturation is needed.
  - Default is truncation (floor).
  - The k = 0 output equals prev, i.e. the previous input passes through exactly.
- Dout and dout_valid are registered.
  - The first output for an accepted input is valid in the cycle after the accept (latency 1).
  - Dout is updated only on an output handshake or on an input accept.
- FSM:
  - WAIT: dout_valid = 0; din_ready = 1. On accept, go to EMIT.
  - EMIT: dout_valid = 1.
    - On dout_ready with k < L-1: k increments and Dout recomputes.
    - On dout_ready with k = L-1: the phase for this input is complete.
    - Without dout_ready: Dout, k and dout_valid hold (no-drop backpressure).
- din_ready = (state == WAIT) || (state == EMIT && k == L-1 && dout_ready). This path is combinational from dout_ready.
- Last output handshake while din_valid = 1: the new input is accepted in the same cycle and the FSM stays in EMIT with k = 0 and the new prev/cur. There is no bubble, so continuous output is possible.
- Last output handshake while din_valid = 0: go to WAIT; dout_valid = 0 next cycle.
- First input after reset: interpolates from prev = 0 (ramp-up from zero). This is intended.
- Reset in any state, including mid-EMIT: all state is cleared next cycle and any pending outputs are discarded.
- Reset has priority over simultaneous handshakes.
- din_valid while din_ready = 0 is ignored; the source must hold Din until it is accepted.

Optional Feature:
- Macro: LIN_INTERP_ROUND_EN.
- Defined: Dout = ((L-k)*prev + k*cur + L/2) >> LOG2_L, i.e. round half up. The result still fits in WIDTH, because the maximum is (L*255 + L/2) >> LOG2_L = 255.
- Undefined: truncation, as in Behaviour.
- Latency and handshakes are identical in both builds.

Test Plan:
- Reset, then inputs 100 and 200, with dout_ready = 1 -> Dout sequence 0, 25, 50, 75, 100, 125, 150, 175.
- After 200, input 0 -> 200, 150, 100, 50. After 0, input 255 -> 0, 63, 127, 191 (truncated).
- Backpressure: after input 100 following reset, hold dout_ready = 0 for 3 cycles at k = 1 -> Dout held at 25, dout_valid held at 1, din_ready = 0; on release the sequence continues 50, 75.
- Throughput: din_valid held at 1 with incrementing samples, dout_ready = 1 -> dout_valid stays 1 continuously after the first output; din_ready pulses once every 4 cycles, coincident with k = 3.
- Reset asserted mid-EMIT at k = 2 -> next cycle dout_valid = 0 and din_ready = 1. A following input of 80 yields 0, 20, 40, 60 (prev was cleared).
- LIN_INTERP_ROUND_EN build: prev = 0, cur = 3 -> 0, 1, 2, 2. The default build gives 0, 0, 1, 2 for the same inputs.
